// File: rtl/trojan1_seq_trigger.sv
// Trojan1 trigger responder: watches the serial r1 stream for a programmable
// bit pattern, counts hits within a sliding timeout window, and fires a
// fixed-length trigger pulse followed by a cooldown once enough hits arrive.
module trojan1_seq_trigger #(
  parameter int                 SEQ_LEN         = 4,
  parameter logic [SEQ_LEN-1:0] SEQ_PATTERN     = 4'b1011,
  parameter int                 MATCH_THRESHOLD = 3,
  parameter int                 WINDOW          = 16,
  parameter int                 PULSE_LEN       = 2,
  parameter int                 COOLDOWN_LEN    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       r1,
  output logic       trigger,
  output logic       armed,
  output logic [3:0] hit_count,
  output logic [7:0] fire_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    FIRE     = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  localparam logic [3:0] THRESH     = 4'(MATCH_THRESHOLD);
  localparam logic [7:0] WIN_LAST   = 8'(WINDOW - 1);
  localparam logic [3:0] PULSE_LAST = 4'(PULSE_LEN - 1);
  localparam logic [7:0] COOL_LAST  = 8'(COOLDOWN_LEN - 1);
  localparam bit         NO_COOL    = (COOLDOWN_LEN == 0);
  localparam bit         ONE_HIT    = (MATCH_THRESHOLD == 1);

  state_t             state;
  logic [SEQ_LEN-1:0] hist;
  logic [7:0]         win_cnt;
  logic [3:0]         pulse_cnt;
  logic [7:0]         cool_cnt;
  logic               match;

  // Oldest sample sits in the MSB, so the pattern reads left to right in time.
  assign match   = (hist == SEQ_PATTERN);
  assign trigger = (state == FIRE);
  assign armed   = (state == ARMED);

  // Shift r1 into the history every cycle regardless of FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= '0;
    end else begin
      hist <= {hist[SEQ_LEN-2:0], r1};
    end
  end

  // Hit counting, windowed arming, trigger pulse and cooldown sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hit_count  <= 4'd0;
      fire_count <= 8'd0;
      win_cnt    <= 8'd0;
      pulse_cnt  <= 4'd0;
      cool_cnt   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (match) begin
            win_cnt   <= 8'd0;
            pulse_cnt <= 4'd0;
            if (ONE_HIT) begin
              state      <= FIRE;
              hit_count  <= 4'd0;
              fire_count <= (fire_count == 8'hFF) ? fire_count : fire_count + 8'd1;
            end else begin
              state     <= ARMED;
              hit_count <= 4'd1;
            end
          end
        end
        ARMED: begin
          if (match) begin
            win_cnt <= 8'd0;
            if (hit_count + 4'd1 == THRESH) begin
              state      <= FIRE;
              hit_count  <= 4'd0;
              pulse_cnt  <= 4'd0;
              fire_count <= (fire_count == 8'hFF) ? fire_count : fire_count + 8'd1;
            end else begin
              hit_count <= hit_count + 4'd1;
            end
          end else if (win_cnt == WIN_LAST) begin
            state     <= IDLE;
            hit_count <= 4'd0;
            win_cnt   <= 8'd0;
          end else begin
            win_cnt <= win_cnt + 8'd1;
          end
        end
        FIRE: begin
          if (pulse_cnt == PULSE_LAST) begin
            pulse_cnt <= 4'd0;
            cool_cnt  <= 8'd0;
            state     <= NO_COOL ? IDLE : COOLDOWN;
          end else begin
            pulse_cnt <= pulse_cnt + 4'd1;
          end
        end
        COOLDOWN: begin
          if (cool_cnt == COOL_LAST) begin
            state    <= IDLE;
            cool_cnt <= 8'd0;
          end else begin
            cool_cnt <= cool_cnt + 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          hit_count <= 4'd0;
          win_cnt   <= 8'd0;
          pulse_cnt <= 4'd0;
          cool_cnt  <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trojan1_seq_trigger.sv
// Directed bench for trojan1_seq_trigger: a cycle-by-cycle vector table for
// the default configuration plus a second instance (one hit, no cooldown)
// driven with a repeating pattern to exercise fire_count saturation.
module tb_trojan1_seq_trigger;

  typedef struct {
    logic       rst;
    logic       r1;
    int         reps;
    logic       trig;
    logic       armed;
    logic [3:0] hit;
    logic [7:0] fire;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       r1 = 1'b0;
  logic       trigger;
  logic       armed;
  logic [3:0] hit_count;
  logic [7:0] fire_count;

  logic       rst_s = 1'b1;
  logic       r1_s = 1'b0;
  logic       trigger_s;
  logic       armed_s;
  logic [3:0] hit_count_s;
  logic [7:0] fire_count_s;

  int   checks = 0;
  int   failures = 0;
  int   step = 0;
  vec_t vecs[$];

  trojan1_seq_trigger dut (
    .clk        (clk),
    .rst        (rst),
    .r1         (r1),
    .trigger    (trigger),
    .armed      (armed),
    .hit_count  (hit_count),
    .fire_count (fire_count)
  );

  trojan1_seq_trigger #(
    .MATCH_THRESHOLD (1),
    .COOLDOWN_LEN    (0)
  ) dut_sat (
    .clk        (clk),
    .rst        (rst_s),
    .r1         (r1_s),
    .trigger    (trigger_s),
    .armed      (armed_s),
    .hit_count  (hit_count_s),
    .fire_count (fire_count_s)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  function automatic void add_vec(input logic v_rst, input logic v_r1, input int v_reps,
                                  input logic v_trig, input logic v_armed,
                                  input logic [3:0] v_hit, input logic [7:0] v_fire);
    vec_t v;
    v.rst   = v_rst;
    v.r1    = v_r1;
    v.reps  = v_reps;
    v.trig  = v_trig;
    v.armed = v_armed;
    v.hit   = v_hit;
    v.fire  = v_fire;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL step %0d %s: got %0d, expected %0d", step, name, actual, expected);
    end
  endtask

  // One clock of the main instance: drive at negedge, sample 1 unit after posedge.
  task automatic applyStimulus(input logic v_rst, input logic v_r1);
    @(negedge clk);
    rst = v_rst;
    r1  = v_r1;
    @(posedge clk);
    #1;
    step++;
  endtask

  initial begin
    // Reset held for 5 cycles with r1 toggling
    add_vec(1, 1, 1, 0, 0, 0, 0);
    add_vec(1, 0, 1, 0, 0, 0, 0);
    add_vec(1, 1, 1, 0, 0, 0, 0);
    add_vec(1, 1, 1, 0, 0, 0, 0);
    add_vec(1, 0, 1, 0, 0, 0, 0);
    add_vec(0, 0, 3, 0, 0, 0, 0);
    // Single hit then 16-cycle timeout
    add_vec(0, 1, 1, 0, 0, 0, 0);
    add_vec(0, 0, 1, 0, 0, 0, 0);
    add_vec(0, 1, 1, 0, 0, 0, 0);
    add_vec(0, 1, 1, 0, 0, 0, 0);
    add_vec(0, 0, 16, 0, 1, 1, 0);
    add_vec(0, 0, 1, 0, 0, 0, 0);
    add_vec(0, 0, 3, 0, 0, 0, 0);
    // Second hit lands exactly on the timeout cycle: match wins
    add_vec(0, 1, 1, 0, 0, 0, 0);
    add_vec(0, 0, 1, 0, 0, 0, 0);
    add_vec(0, 1, 1, 0, 0, 0, 0);
    add_vec(0, 1, 1, 0, 0, 0, 0);
    add_vec(0, 0, 12, 0, 1, 1, 0);
    add_vec(0, 1, 1, 0, 1, 1, 0);
    add_vec(0, 0, 1, 0, 1, 1, 0);
    add_vec(0, 1, 1, 0, 1, 1, 0);
    add_vec(0, 1, 1, 0, 1, 1, 0);
    add_vec(0, 0, 1, 0, 1, 2, 0);
    add_vec(0, 0, 15, 0, 1, 2, 0);
    add_vec(0, 0, 1, 0, 0, 0, 0);
    add_vec(0, 0, 3, 0, 0, 0, 0);
    // Three back-to-back patterns fire
    add_vec(0, 1, 1, 0, 0, 0, 0);
    add_vec(0, 0, 1, 0, 0, 0, 0);
    add_vec(0, 1, 1, 0, 0, 0, 0);
    add_vec(0, 1, 1, 0, 0, 0, 0);
    add_vec(0, 1, 1, 0, 1, 1, 0);
    add_vec(0, 0, 1, 0, 1, 1, 0);
    add_vec(0, 1, 1, 0, 1, 1, 0);
    add_vec(0, 1, 1, 0, 1, 1, 0);
    add_vec(0, 1, 1, 0, 1, 2, 0);
    add_vec(0, 0, 1, 0, 1, 2, 0);
    add_vec(0, 1, 1, 0, 1, 2, 0);
    add_vec(0, 1, 1, 0, 1, 2, 0);
    add_vec(0, 0, 2, 1, 0, 0, 1);
    // Cooldown with a full pattern inside it is ignored
    add_vec(0, 0, 2, 0, 0, 0, 1);
    add_vec(0, 1, 1, 0, 0, 0, 1);
    add_vec(0, 0, 1, 0, 0, 0, 1);
    add_vec(0, 1, 1, 0, 0, 0, 1);
    add_vec(0, 1, 1, 0, 0, 0, 1);
    add_vec(0, 0, 6, 0, 0, 0, 1);
    // Overlapping occurrences 1011011011
    add_vec(0, 1, 1, 0, 0, 0, 1);
    add_vec(0, 0, 1, 0, 0, 0, 1);
    add_vec(0, 1, 1, 0, 0, 0, 1);
    add_vec(0, 1, 1, 0, 0, 0, 1);
    add_vec(0, 0, 1, 0, 1, 1, 1);
    add_vec(0, 1, 2, 0, 1, 1, 1);
    add_vec(0, 0, 1, 0, 1, 2, 1);
    add_vec(0, 1, 2, 0, 1, 2, 1);
    add_vec(0, 0, 2, 1, 0, 0, 2);
    add_vec(0, 0, 10, 0, 0, 0, 2);
    // Fire again, then reset in the first FIRE cycle
    add_vec(0, 1, 1, 0, 0, 0, 2);
    add_vec(0, 0, 1, 0, 0, 0, 2);
    add_vec(0, 1, 1, 0, 0, 0, 2);
    add_vec(0, 1, 1, 0, 0, 0, 2);
    add_vec(0, 1, 1, 0, 1, 1, 2);
    add_vec(0, 0, 1, 0, 1, 1, 2);
    add_vec(0, 1, 2, 0, 1, 1, 2);
    add_vec(0, 1, 1, 0, 1, 2, 2);
    add_vec(0, 0, 1, 0, 1, 2, 2);
    add_vec(0, 1, 2, 0, 1, 2, 2);
    add_vec(0, 0, 1, 1, 0, 0, 3);
    add_vec(1, 0, 1, 0, 0, 0, 0);
    add_vec(0, 0, 4, 0, 0, 0, 0);

    $display("[TB] applying %0d vector records", vecs.size());
    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].reps; k++) begin
        applyStimulus(vecs[i].rst, vecs[i].r1);
        checkOutput("trigger", int'(trigger), int'(vecs[i].trig));
        checkOutput("armed", int'(armed), int'(vecs[i].armed));
        checkOutput("hit_count", int'(hit_count), int'(vecs[i].hit));
        checkOutput("fire_count", int'(fire_count), int'(vecs[i].fire));
      end
    end

    // Saturation instance: repeating 1011 fires on edges 5, 9, 13, ...
    $display("[TB] fire_count saturation run");
    @(negedge clk);
    rst_s = 1'b1;
    r1_s  = 1'b0;
    @(negedge clk);
    begin
      logic [3:0] pat;
      pat = 4'b1011;
      for (int e = 1; e <= 1210; e++) begin
        @(negedge clk);
        rst_s = 1'b0;
        r1_s  = pat[3 - ((e - 1) % 4)];
        @(posedge clk);
        #1;
        step = e;
        if (e == 4) begin
          checkOutput("sat_trigger_e4", int'(trigger_s), 0);
          checkOutput("sat_hit_e4", int'(hit_count_s), 0);
        end
        if (e == 5) begin
          checkOutput("sat_trigger_e5", int'(trigger_s), 1);
          checkOutput("sat_armed_e5", int'(armed_s), 0);
          checkOutput("sat_fire_e5", int'(fire_count_s), 1);
        end
        if (e == 7) checkOutput("sat_trigger_e7", int'(trigger_s), 0);
        if (e == 801) checkOutput("sat_fire_e801", int'(fire_count_s), 200);
        if (e == 1210) begin
          checkOutput("sat_fire_e1210", int'(fire_count_s), 255);
          checkOutput("sat_trigger_e1210", int'(trigger_s), 1);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
